// File: rtl/mem_ops_pkg.sv
// Shared definitions for the LSU memory master.
// Holds the LA32R load/store opcode encodings, the FSM state enum, the
// op-field positions and the opcode classification helpers.
package mem_ops_pkg;

    // Opcode layout: op[1:0] = size, op[2] = unsigned load, op[3] = store
    localparam logic [3:0] LD_B  = 4'd0;
    localparam logic [3:0] LD_H  = 4'd1;
    localparam logic [3:0] LD_W  = 4'd2;
    localparam logic [3:0] LD_BU = 4'd4;
    localparam logic [3:0] LD_HU = 4'd5;
    localparam logic [3:0] ST_B  = 4'd8;
    localparam logic [3:0] ST_H  = 4'd9;
    localparam logic [3:0] ST_W  = 4'd10;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int OP_UNS_BIT = 2;
    localparam int OP_ST_BIT  = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_e;

    function automatic logic op_known(input logic [3:0] op);
        case (op)
            LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Unknown opcodes never fault; they complete with zero data.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        if (!op_known(op)) return 1'b0;
        case (op[1:0])
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for a word-only memory.
// Ports:
//   size_i   access size (op[1:0])
//   uns_i    zero-extend loads when set (op[2])
//   off_i    byte offset within the word (addr[1:0])
//   word_i   memory word (read word for loads, old word for merges)
//   wdata_i  right-aligned store data
//   ld_o     extracted and extended load data
//   st_o     word to write: word_i with the addressed lane(s) replaced,
//            or wdata_i for a full-word store
module lsu_align
    import mem_ops_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [15:0] lane;

    always_comb begin
        // Bring the addressed lane down to bit 0
        lane = 16'(word_i >> {off_i, 3'b000});
        case (size_i)
            SZ_B:    ld_o = uns_i ? {24'b0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
            SZ_H:    ld_o = uns_i ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ld_o = word_i;
        endcase
    end

    always_comb begin
        st_o = word_i;
        case (size_i)
            SZ_B:    st_o[{off_i, 3'b000} +: 8]        = wdata_i[7:0];
            SZ_H:    st_o[{off_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
            default: st_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data memory with an asynchronous
// read port. One request in flight; sub-word stores use read-modify-write.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/ready      request handshake (ready only in IDLE)
//   req_op/addr/wdata    opcode, byte address, right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata/ale       load data / alignment error, held until next response
//   mem_a/d/we           memory word address, write word, write enable
//   mem_spo              combinational read word at mem_a
module lsu_mem_master
    import mem_ops_pkg::*;
#(
    parameter int DATA_MEM_DEPTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [3:0]                req_op,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_ale,
    output logic [DATA_MEM_DEPTH-1:0] mem_a,
    output logic [31:0]               mem_d,
    output logic                      mem_we,
    input  logic [31:0]               mem_spo
);

    localparam int AW = DATA_MEM_DEPTH + 2;

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       old_q, old_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ale_q, ale_d;
    logic              we_raw;
    logic [31:0]       ld_word, st_word;

    // Address bits above the memory wrap silently
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    // ACCESS extracts from the live read word; WRITE merges into the saved one
    lsu_align u_align (
        .size_i  (op_q[1:0]),
        .uns_i   (op_q[OP_UNS_BIT]),
        .off_i   (addr_q[1:0]),
        .word_i  ((state_q == WRITE) ? old_q : mem_spo),
        .wdata_i (wdata_q),
        .ld_o    (ld_word),
        .st_o    (st_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            ale_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            ale_q   <= ale_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        old_d     = old_q;
        rdata_d   = rdata_q;
        ale_d     = ale_q;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        we_raw    = 1'b0;
        mem_a     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    if (op_misaligned(req_op, req_addr[1:0])) begin
                        rdata_d = '0;
                        ale_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_a = addr_q[AW-1:2];
                if (op_known(op_q) && op_q[OP_ST_BIT] && op_q != ST_W) begin
                    old_d   = mem_spo;
                    state_d = WRITE;
                end else begin
                    // Stores and unknown opcodes report zero data
                    rdata_d = (op_known(op_q) && !op_q[OP_ST_BIT]) ? ld_word : '0;
                    ale_d   = 1'b0;
                    we_raw  = (op_q == ST_W);
                    state_d = RESP;
                end
            end
            WRITE: begin
                mem_a   = addr_q[AW-1:2];
                we_raw  = 1'b1;
                rdata_d = '0;
                ale_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset in the write cycle must not reach the memory
    assign mem_we     = we_raw && !rst;
    assign mem_d      = mem_we ? st_word : '0;
    assign resp_rdata = rdata_q;
    assign resp_ale   = ale_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
    localparam int DEPTH = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_ale;
    logic [DEPTH-1:0] mem_a;
    logic [31:0]      mem_d;
    logic             mem_we;
    logic [31:0]      mem_spo;

    logic [31:0] mem [0:(1<<DEPTH)-1];

    typedef struct {
        logic [31:0] rdata;
        logic        ale;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    lsu_mem_master #(.DATA_MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ale(resp_ale),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    assign mem_spo = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Issue one request from IDLE and observe it to completion.
    // Entered and left at #1 after a posedge. lat=0 means no response.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic ale,
                          output int we_cnt, output int we_cyc,
                          output logic [DEPTH-1:0] we_a, output logic [31:0] we_d,
                          output int rdy_bad);
        bit done = 0;
        lat = 0; rd = 'x; ale = 1'bx; we_cnt = 0; we_cyc = 0; we_a = '0; we_d = '0; rdy_bad = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        if (!req_ready) rdy_bad++;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'hF; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; we_cyc = c; we_a = mem_a; we_d = mem_d; end
            if (req_ready) rdy_bad++;
            if (resp_valid) begin lat = c; rd = resp_rdata; ale = resp_ale; done = 1; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_ale, mem_we} !== 4'b1000) $display("FAIL reset_ctrl: got %b want 1000", {req_ready, resp_valid, resp_ale, mem_we});
        else n_pass++;
        n_checks++;
        if ({resp_rdata, mem_a, mem_d} !== '0) $display("FAIL reset_data: rdata=%h a=%h d=%h want 0", resp_rdata, mem_a, mem_d);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [3:0]  ops [5] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2};
        logic [31:0] adr [5] = '{32'h6, 32'h6, 32'h6, 32'h4, 32'h104};
        logic [31:0] exd [5] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_7F02, 32'h80F1_7F02};
        int lat, wc, wcy, rb; logic [31:0] rd, wd; logic ale; logic [DEPTH-1:0] wa; exp_t e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{exd[i], 1'b0, 2});
            do_req(ops[i], adr[i], 32'h0, lat, rd, ale, wc, wcy, wa, wd, rb);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== e.lat || rd !== e.rdata || ale !== e.ale)
                $display("FAIL load_%0d: lat=%0d rdata=%h ale=%b want lat=%0d rdata=%h ale=%b", i, lat, rd, ale, e.lat, e.rdata, e.ale);
            else n_pass++;
            n_checks++;
            if (wc !== 0 || rb !== 0) $display("FAIL load_side_%0d: we_pulses=%0d ready_busy=%0d want 0/0", i, wc, rb);
            else n_pass++;
        end
    endtask

    task automatic test_store_byte();
        int lat, wc, wcy, rb; logic [31:0] rd, wd; logic ale; logic [DEPTH-1:0] wa; exp_t e;
        exp_q.push_back('{32'h0, 1'b0, 3});
        do_req(4'd8, 32'h5, 32'h1234_56AA, lat, rd, ale, wc, wcy, wa, wd, rb);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== e.lat || rd !== e.rdata || ale !== e.ale) $display("FAIL st_b_resp: lat=%0d rdata=%h ale=%b want lat=%0d rdata=0 ale=0", lat, rd, ale, e.lat);
        else n_pass++;
        n_checks++;
        if (wc !== 1 || wcy !== 2 || wa !== 6'd1 || wd !== 32'h80F1_AA02)
            $display("FAIL st_b_write: pulses=%0d cycle=%0d a=%0d d=%h want 1/2/1/80f1aa02", wc, wcy, wa, wd);
        else n_pass++;
        exp_q.push_back('{32'h80F1_AA02, 1'b0, 2});
        do_req(4'd2, 32'h4, 32'h0, lat, rd, ale, wc, wcy, wa, wd, rb);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== e.lat || rd !== e.rdata) $display("FAIL st_b_readback: lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rd, e.lat, e.rdata);
        else n_pass++;
    endtask

    task automatic test_store_word_half();
        int lat, wc, wcy, rb; logic [31:0] rd, wd; logic ale; logic [DEPTH-1:0] wa; exp_t e;
        exp_q.push_back('{32'h0, 1'b0, 2});
        do_req(4'd10, 32'h8, 32'hDEAD_BEEF, lat, rd, ale, wc, wcy, wa, wd, rb);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== e.lat || rd !== e.rdata || ale !== e.ale) $display("FAIL st_w_resp: lat=%0d rdata=%h ale=%b want lat=2 rdata=0 ale=0", lat, rd, ale);
        else n_pass++;
        n_checks++;
        if (wc !== 1 || wcy !== 1 || wa !== 6'd2 || wd !== 32'hDEAD_BEEF)
            $display("FAIL st_w_write: pulses=%0d cycle=%0d a=%0d d=%h want 1/1/2/deadbeef", wc, wcy, wa, wd);
        else n_pass++;
        exp_q.push_back('{32'h0, 1'b0, 3});
        do_req(4'd9, 32'hA, 32'h0000_CAFE, lat, rd, ale, wc, wcy, wa, wd, rb);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== e.lat || wc !== 1 || wcy !== 2) $display("FAIL st_h_timing: lat=%0d pulses=%0d cycle=%0d want 3/1/2", lat, wc, wcy);
        else n_pass++;
        n_checks++;
        if (mem[2] !== 32'hCAFE_BEEF) $display("FAIL st_h_mem: mem[2]=%h want cafebeef", mem[2]);
        else n_pass++;
    endtask

    task automatic test_misaligned_unknown();
        logic [3:0]  ops [3] = '{4'd1, 4'd10, 4'd3};
        logic [31:0] adr [3] = '{32'h3, 32'h2, 32'h8};
        logic        exa [3] = '{1'b1, 1'b1, 1'b0};
        int          exl [3] = '{1, 1, 2};
        logic [31:0] m1, m2;
        int lat, wc, wcy, rb; logic [31:0] rd, wd; logic ale; logic [DEPTH-1:0] wa; exp_t e;
        m1 = mem[1]; m2 = mem[2];
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{32'h0, exa[i], exl[i]});
            do_req(ops[i], adr[i], 32'h5555_5555, lat, rd, ale, wc, wcy, wa, wd, rb);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== e.lat || rd !== e.rdata || ale !== e.ale || wc !== 0)
                $display("FAIL odd_%0d: lat=%0d rdata=%h ale=%b we=%0d want lat=%0d rdata=0 ale=%b we=0", i, lat, rd, ale, wc, e.lat, e.ale);
            else n_pass++;
        end
        n_checks++;
        if (mem[1] !== m1 || mem[2] !== m2) $display("FAIL odd_mem: mem1=%h mem2=%h want %h %h", mem[1], mem[2], m1, m2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] m1 = mem[1];
        int bad = 0;
        req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h5; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;        // accepted
        req_valid = 1'b0;
        @(posedge clk); #1;        // now in WRITE
        rst = 1'b1;
        @(negedge clk);
        if (mem_we !== 1'b0 || resp_valid !== 1'b0) bad++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rst_mid_idle: ready=%b resp=%b want 1/0", req_ready, resp_valid);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        if (resp_valid !== 1'b0) bad++;
        n_checks++;
        if (bad !== 0 || mem[1] !== m1) $display("FAIL rst_mid_write: bad=%0d mem1=%h want 0 %h", bad, mem[1], m1);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'd10, 4'd0, 4'd9, 4'd2};
        logic [31:0] adr [4] = '{32'h10, 32'h11, 32'h12, 32'h10};
        logic [31:0] wds [4] = '{32'h1122_3344, 32'h0, 32'hAAAA_5555, 32'h0};
        logic [31:0] exd [4] = '{32'h0, 32'h0000_0033, 32'h0, 32'h5555_3344};
        int idx = 0, nresp = 0, bad = 0;
        bit busy = 0, acc;
        exp_t e;
        req_valid = 1'b1; req_op = ops[0]; req_addr = adr[0]; req_wdata = wds[0];
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            @(negedge clk);
            if (busy && req_ready) bad++;
            if (resp_valid) begin
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (resp_rdata !== e.rdata || resp_ale !== e.ale)
                        $display("FAIL b2b_resp_%0d: rdata=%h ale=%b want %h %b", nresp, resp_rdata, resp_ale, e.rdata, e.ale);
                    else n_pass++;
                end
                nresp++;
                busy = 0;
            end
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back('{exd[idx], 1'b0, 0});
                busy = 1;
                idx++;
                if (idx < 4) begin req_op = ops[idx]; req_addr = adr[idx]; req_wdata = wds[idx]; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (idx !== 4 || nresp !== 4 || bad !== 0)
            $display("FAIL b2b_flow: accepts=%0d resps=%0d bad=%0d want 4/4/0", idx, nresp, bad);
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 32'h0;
        mem[1] = 32'h80F1_7F02;
        test_reset();
        test_loads();
        test_store_byte();
        test_store_word_half();
        test_misaligned_unknown();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
